gemm_tile_controller: RTL and testbench
=======================================

Name: gemm_tile_controller

Overview:
- Sequencer for the GEMM accelerator datapath (M x K by K x N tile MAC array).
- Walks output tiles of C = A*B for runtime sizes M_size_i/K_size_i/N_size_i and drives tile addresses to SRAM A, B and C.
- Issues accumulate-clear, accumulate-valid and last-K-tile strobes to the MAC array, plus C write enables.
- Tile-packed memory layout: A addr = mt*Kt+kt, B addr = kt*Nt+nt, C addr = mt*Nt+nt, where Mt=M_size_i/M, Kt=K_size_i/K, Nt=N_size_i/N.

Parameters:
- M, 8: tile rows of A/C per SRAM word.
- K, 4: tile depth per SRAM word; power of two.
- N, 2: tile columns of B/C per SRAM word; power of two.
- AddrWidth, 6: SRAM address width; depth = 2**AddrWidth.
- SizeAddrWidth, 8: width of the runtime size inputs.
- Constraint: M, K and N are all powers of two.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE.
- M_size_i  in  SizeAddrWidth  rows of A/C; latched at start.
- K_size_i  in  SizeAddrWidth  inner dimension; latched at start.
- N_size_i  in  SizeAddrWidth  columns of B/C; latched at start.
- sram_a_addr_o  out  AddrWidth  A tile read address.
- sram_b_addr_o  out  AddrWidth  B tile read address.
- sram_c_addr_o  out  AddrWidth  C tile write address.
- sram_c_we_o  out  1  C write enable.
- mac_valid_o  out  1  SRAM read data is valid this cycle; MAC array must accumulate.
- acc_clr_o  out  1  with mac_valid_o: load the product, do not add to the old accumulator (kt==0).
- acc_last_o  out  1  with mac_valid_o: final K tile for this output tile.
- busy_o  out  1  high from the cycle after an accepted start until done_o inclusive.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse coincident with done_o when the sizes are rejected.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset during any state aborts within one cycle; no sram_c_we_o after the reset edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Cycle numbering: cycle 0 is the cycle in which start_i is sampled high in IDLE. Sizes are latched at that edge.
- Size validation, evaluated at cycle 0. Reject if any of these hold:
  - any size is 0;
  - M_size_i%M, K_size_i%K or N_size_i%N is nonzero (mask check);
  - Mt*Kt, Kt*Nt or Mt*Nt exceeds 2**AddrWidth.
- On reject: go to DONE; done_o=1 and err_o=1 in cycle 1; no reads, no writes.
- RUN: issues one (A,B) address pair per cycle, in cycles 1..T, where T = Mt*Nt*Kt.
  - Loop order: mt outer, nt middle, kt inner. No bubbles, including between output tiles.
  - Addresses are built incrementally with adders; no multipliers.
- Read latency is 1 cycle. For an address issued in cycle c:
  - mac_valid_o=1 in cycle c+1;
  - acc_clr_o=1 when kt==0;
  - acc_last_o=1 when kt==Kt-1; with Kt=1, clr and last assert together.
- Write stage: sram_c_we_o=1 in cycle c+2 for every issue with kt==Kt-1, with sram_c_addr_o=mt*Nt+nt of that tile. The write of tile i overlaps issue of tile i+1.
- DRAIN: 2 cycles (T+1, T+2) flush the pipeline. DONE: done_o=1 in cycle T+3, then IDLE; busy_o=0 from cycle T+4.
- Output values outside their valid cycles:
  - address outputs hold 0 in IDLE/DONE;
  - sram_c_addr_o holds 0 when sram_c_we_o=0.
- start_i while busy is ignored. start_i in the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted.
- Latched sizes are unaffected by input changes after cycle 0.
- Total latency, accepted start to done_o: T+3 cycles.

Test Plan:
- M=8,K=4,N=2 (T=1), start at cycle 0 -> cycle 1 a=0,b=0; cycle 2 mac_valid, clr and last all 1; cycle 3 we=1, c=0; cycle 4 done=1, err=0.
- M=16,K=8,N=4 (Mt=Kt=Nt=2, T=8) -> (a,b) sequence (0,0),(1,2),(0,1),(1,3),(2,0),(3,2),(2,1),(3,3) in cycles 1..8; clr in cycles 2,4,6,8; we in cycles 4,6,8,10 with c=0,1,2,3; done in cycle 11.
- M=32,K=32,N=32 -> Kt*Nt=128>64; done=1 and err=1 in cycle 1; sram_c_we_o never asserted; mac_valid_o never asserted.
- K=6 (not a multiple of 4), and separately N=0 -> err pulse in cycle 1 each time; a following valid start (8,4,2) completes normally.
- Run M=16,K=8,N=4; pulse start_i in cycle 5 and change sizes -> ignored; sequence identical to scenario 2.
- Run M=16,K=8,N=4; assert rst_i in cycle 6 -> from cycle 7 all outputs 0; no we after reset; new start completes normally.

Source files
------------

// File: rtl/gemm_tile_controller.sv
// GEMM tile sequencer: walks output tiles of C = A*B (mt outer, nt middle,
// kt inner), issues one A/B tile read per cycle and steers the MAC array
// accumulate strobes and the C write-back one and two cycles later.
module gemm_tile_controller #(
  parameter int M             = 8,
  parameter int K             = 4,
  parameter int N             = 2,
  parameter int AddrWidth     = 6,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_valid_o,
  output logic                     acc_clr_o,
  output logic                     acc_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int SW  = SizeAddrWidth;
  localparam int AW  = AddrWidth;
  localparam int PW  = 2 * SizeAddrWidth;
  localparam int MSH = $clog2(M);
  localparam int KSH = $clog2(K);
  localparam int NSH = $clog2(N);
  localparam logic [PW-1:0] DEPTH = PW'(2 ** AddrWidth);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic          err_r;
  logic          drain_cnt;
  logic [SW-1:0] mt, nt, kt;
  logic [SW-1:0] mt_lim, nt_lim, kt_lim;
  logic [AW-1:0] kt_len, nt_len;
  logic [AW-1:0] a_addr, b_addr, a_base, c_cur;

  // Tile counts and size validation, only meaningful while start_i is sampled in IDLE.
  logic [SW-1:0] mt_in, kt_in, nt_in;
  logic [PW-1:0] p_mk, p_kn, p_mn;
  logic          size_ok;
  assign mt_in = M_size_i >> MSH;
  assign kt_in = K_size_i >> KSH;
  assign nt_in = N_size_i >> NSH;
  assign p_mk  = PW'(mt_in) * PW'(kt_in);
  assign p_kn  = PW'(kt_in) * PW'(nt_in);
  assign p_mn  = PW'(mt_in) * PW'(nt_in);
  assign size_ok = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0)
                && ((M_size_i & SW'(M - 1)) == '0)
                && ((K_size_i & SW'(K - 1)) == '0)
                && ((N_size_i & SW'(N - 1)) == '0)
                && (p_mk <= DEPTH) && (p_kn <= DEPTH) && (p_mn <= DEPTH);

  logic issue, kt_end, nt_end, mt_end, accept;
  assign accept = (state == S_IDLE) && start_i;
  assign issue  = (state == S_RUN);
  assign kt_end = (kt == kt_lim);
  assign nt_end = (nt == nt_lim);
  assign mt_end = (mt == mt_lim);

  logic          vld_p1, clr_p1, last_p1;
  logic [AW-1:0] c_p1;
  logic          we_p2;
  logic [AW-1:0] c_p2;

  // Control: FSM, tile loop counters and pipeline valids.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      err_r     <= 1'b0;
      drain_cnt <= 1'b0;
      mt        <= '0;
      nt        <= '0;
      kt        <= '0;
      vld_p1    <= 1'b0;
      we_p2     <= 1'b0;
    end else begin
      vld_p1 <= issue;
      we_p2  <= vld_p1 & last_p1;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mt    <= '0;
            nt    <= '0;
            kt    <= '0;
            err_r <= !size_ok;
            state <= size_ok ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!kt_end) begin
            kt <= kt + 1'b1;
          end else begin
            kt <= '0;
            if (!nt_end) begin
              nt <= nt + 1'b1;
            end else begin
              nt <= '0;
              if (!mt_end) begin
                mt <= mt + 1'b1;
              end else begin
                mt        <= '0;
                drain_cnt <= 1'b0;
                state     <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_DONE;
        end
        default: begin
          err_r <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p0: latched tile geometry and incremental A/B/C address generation.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mt_lim <= mt_in - 1'b1;
      nt_lim <= nt_in - 1'b1;
      kt_lim <= kt_in - 1'b1;
      kt_len <= AW'(kt_in);
      nt_len <= AW'(nt_in);
      a_addr <= '0;
      b_addr <= '0;
      a_base <= '0;
      c_cur  <= '0;
    end else if (issue) begin
      if (!kt_end) begin
        a_addr <= a_addr + ONE_A;
        b_addr <= b_addr + nt_len;
      end else if (!nt_end) begin
        a_addr <= a_base;
        b_addr <= AW'(nt + 1'b1);
        c_cur  <= c_cur + ONE_A;
      end else if (!mt_end) begin
        a_base <= a_base + kt_len;
        a_addr <= a_base + kt_len;
        b_addr <= '0;
        c_cur  <= c_cur + ONE_A;
      end
    end
  end

  // Stage p1/p2: accumulate strobes follow the read by one cycle, C write by two.
  always_ff @(posedge clk_i) begin
    clr_p1  <= (kt == '0);
    last_p1 <= kt_end;
    c_p1    <= c_cur;
    c_p2    <= c_p1;
  end

  assign sram_a_addr_o = issue ? a_addr : '0;
  assign sram_b_addr_o = issue ? b_addr : '0;
  assign sram_c_we_o   = we_p2;
  assign sram_c_addr_o = we_p2 ? c_p2 : '0;
  assign mac_valid_o   = vld_p1;
  assign acc_clr_o     = vld_p1 & clr_p1;
  assign acc_last_o    = vld_p1 & last_p1;
  assign busy_o        = (state != S_IDLE);
  assign done_o        = (state == S_DONE);
  assign err_o         = (state == S_DONE) & err_r;

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Scoreboard bench for gemm_tile_controller: a tile-loop reference model
// queues expected reads, writes and completions; a monitor pops and compares.
module tb_gemm_tile_controller;
  localparam int M = 8, K = 4, N = 2, AW = 6, SW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [SW-1:0] m_size = '0, k_size = '0, n_size = '0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic c_we, mac_valid, acc_clr, acc_last, busy, done, err;

  gemm_tile_controller #(.M(M), .K(K), .N(N), .AddrWidth(AW), .SizeAddrWidth(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
    .sram_c_we_o(c_we), .mac_valid_o(mac_valid), .acc_clr_o(acc_clr),
    .acc_last_o(acc_last), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int a; int b; bit clr; bit last;} mac_t;
  mac_t mac_q[$];
  int   wr_q[$];
  bit   done_q[$];

  int n_vec = 0, n_miss = 0;
  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain tile loops over the packed layout.
  task automatic model(int ms, int ks, int ns, output int lat, output int t);
    int mtn = ms / M, ktn = ks / K, ntn = ns / N;
    bit rej = (ms == 0) || (ks == 0) || (ns == 0) ||
              (ms % M != 0) || (ks % K != 0) || (ns % N != 0) ||
              (mtn * ktn > DEPTH) || (ktn * ntn > DEPTH) || (mtn * ntn > DEPTH);
    if (rej) begin
      done_q.push_back(1'b1);
      lat = 1;
      t = 0;
    end else begin
      for (int mi = 0; mi < mtn; mi++)
        for (int ni = 0; ni < ntn; ni++) begin
          for (int ki = 0; ki < ktn; ki++)
            mac_q.push_back('{mi * ktn + ki, ki * ntn + ni, ki == 0, ki == ktn - 1});
          wr_q.push_back(mi * ntn + ni);
        end
      done_q.push_back(1'b0);
      t = mtn * ktn * ntn;
      lat = t + 3;
    end
  endtask

  int prev_a = 0, prev_b = 0;
  bit abort = 1'b0;
  int mac_seen, first_mac, last_mac, last_we;

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    mac_t e;
    if (!rst) begin
      if (abort) begin
        chk("abort_strobes", {c_we, mac_valid, acc_clr, acc_last, busy, done, err}, 0);
        chk("abort_addrs", int'(a_addr | b_addr | c_addr), 0);
      end else begin
        if (mac_valid) begin
          mac_seen++;
          if (first_mac < 0) first_mac = cyc;
          last_mac = cyc;
          if (mac_q.size() == 0) chk("mac_unexpected", 1, 0);
          else begin
            e = mac_q.pop_front();
            chk("a_addr", prev_a, e.a);
            chk("b_addr", prev_b, e.b);
            chk("acc_clr", int'(acc_clr), int'(e.clr));
            chk("acc_last", int'(acc_last), int'(e.last));
          end
        end else chk("clr_last_quiet", {acc_clr, acc_last}, 0);
        if (c_we) begin
          last_we = cyc;
          if (wr_q.size() == 0) chk("we_unexpected", 1, 0);
          else chk("c_addr", int'(c_addr), wr_q.pop_front());
        end else chk("c_addr_quiet", int'(c_addr), 0);
        if (done) begin
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else chk("err", int'(err), int'(done_q.pop_front()));
        end else chk("err_quiet", int'(err), 0);
        if (!busy) chk("ab_idle", int'(a_addr | b_addr), 0);
      end
    end
    prev_a = a_addr;
    prev_b = b_addr;
  end

  task automatic rand_sizes();
    m_size = SW'($urandom);
    k_size = SW'($urandom);
    n_size = SW'($urandom);
  endtask

  // Called on a negedge; start is sampled by the following posedge (cycle 0).
  task automatic issue(int ms, int ks, int ns, output int s, output int lat, output int t);
    model(ms, ks, ns, lat, t);
    mac_seen = 0; first_mac = -1; last_mac = -1; last_we = -1;
    m_size = SW'(ms); k_size = SW'(ks); n_size = SW'(ns);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    rand_sizes();
  endtask

  task automatic wait_done(int s, int lat, int t, bit pulse);
    int d = -1;
    for (int i = 0; i < 1000 && d < 0; i++) begin
      if (done) d = cyc;
      else begin
        if (pulse && cyc == s + 5) begin start = 1'b1; rand_sizes(); end
        else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (d < 0) chk("done_timeout", 0, 1);
    else begin
      chk("latency", d - s, lat);
      chk("busy_at_done", int'(busy), 1);
      chk("mac_count", mac_seen, t);
      if (t > 0) begin
        chk("first_mac", first_mac - s, 2);
        chk("mac_span", last_mac - first_mac + 1, t);
        chk("last_we", last_we - s, t + 2);
      end else chk("no_we", last_we, -1);
    end
  endtask

  task automatic run(int ms, int ks, int ns, bit pulse);
    int s, lat, t;
    issue(ms, ks, ns, s, lat, t);
    wait_done(s, lat, t, pulse);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_after_done", int'(done), 0);
  endtask

  initial begin
    int s, lat, t, mode;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {c_we, mac_valid, acc_clr, acc_last, busy, done, err}, 0);
    chk("rst_addrs", int'(a_addr | b_addr | c_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    run(8, 4, 2, 0);
    run(16, 8, 4, 0);
    run(32, 32, 32, 0);
    run(8, 6, 2, 0);
    run(8, 4, 0, 0);
    run(8, 4, 2, 0);
    run(16, 8, 4, 1);

    // Abort by reset in cycle 6 of a run.
    issue(16, 8, 4, s, lat, t);
    while (cyc < s + 6) @(negedge clk);
    rst = 1'b1;
    abort = 1'b1;
    mac_q.delete(); wr_q.delete(); done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b0;
    run(16, 8, 4, 0);

    // Start held through DONE: ignored there, accepted in the next IDLE cycle.
    issue(8, 4, 2, s, lat, t);
    wait_done(s, lat, t, 0);
    start = 1'b1;
    @(negedge clk);
    chk("busy_idle_gap", int'(busy), 0);
    issue(16, 4, 4, s, lat, t);
    wait_done(s, lat, t, 0);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      mode = $urandom_range(0, 4);
      if (mode == 0)
        run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      else
        run(M * $urandom_range(1, 8), K * $urandom_range(1, 8), N * $urandom_range(1, 8), 0);
    end

    chk("mac_q_empty", mac_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
